branch_resolution_unit: RTL and testbench
=========================================

BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 4, prediction-queue entries (power of two, 2..16).
REQ-002 SHALL have port: bru_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: bru_reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: bru_push  in  1  fetch records one prediction this cycle.
REQ-005 SHALL have ports: bru_push_pc in 32, bru_push_pred_taken in 1, bru_push_pred_target in 32; these carry the fetch PC and the BTB prediction.
REQ-006 SHALL have port: bru_full  out  1  queue holds DEPTH entries; fetch stalls.
REQ-007 SHALL have port: bru_resolve  in  1  execute resolves the oldest in-flight instruction.
REQ-008 SHALL have ports: bru_resolve_pc in 32, bru_resolve_is_branch in 1, bru_resolve_taken in 1, bru_resolve_target in 32.
REQ-009 SHALL have ports: bru_btb_write out 1, bru_btb_new_pc out 32, bru_btb_data out 32, bru_btb_branch_taken out 1; these drive the BTB update port.
REQ-010 SHALL have ports: bru_redirect out 1, bru_redirect_pc out 32; these carry the fetch redirect.
REQ-011 SHALL have port: bru_underflow  out  1  sticky flag: resolve arrived while queue empty.

Function
REQ-012 SHALL keep an in-order FIFO of {pc, pred_taken, pred_target} with wrap-around pointers and a count of width $clog2(DEPTH)+1.
REQ-013 SHALL ignore bru_push when bru_full=1, even if a pop occurs in the same cycle.
REQ-014 SHALL perform a push and a non-mispredicting pop in the same cycle, leaving count unchanged.
REQ-015 SHALL pop the head on bru_resolve when not empty; when empty, SHALL set bru_underflow and take no other action.
REQ-016 SHALL declare a mispredict when the head pc differs from resolve_pc; or is_branch=1 and pred_taken differs from taken; or taken=1 and pred_target differs from target; or is_branch=0 and pred_taken=1.
REQ-017 SHALL assert bru_btb_write for exactly one cycle in N+1 for every resolve in cycle N with is_branch=1; new_pc=resolve_pc, data=resolve_target, branch_taken=resolve_taken.
REQ-018 SHALL NOT write the BTB for is_branch=0 resolves.
REQ-019 SHALL, on a mispredict in cycle N, assert bru_redirect for one cycle in N+1. Redirect pc SHALL be resolve_target if is_branch and taken; otherwise resolve_pc+4 (mod 2^32).
REQ-020 SHALL have a two-state FSM. RUN goes to FLUSH on a mispredict. FLUSH always returns to RUN after one cycle.
REQ-021 SHALL clear the queue at the mispredict edge, and SHALL drop any push in cycle N and during FLUSH.
REQ-022 SHALL ignore bru_resolve while in FLUSH.
REQ-023 SHALL register all outputs; bru_full SHALL reflect count after the previous edge.

Reset
REQ-024 SHALL, with bru_reset_n=0 at an edge, empty the queue, enter RUN, and zero every output including bru_underflow. This includes a reset during FLUSH or with a pending redirect.
REQ-025 SHALL NOT require queue payload storage to be reset.

Configuration
REQ-026 SHALL, with BRU_STATS_EN defined, add outputs bru_branch_count (32) and bru_mispredict_count (32). These increment per resolved branch and per mispredict respectively, wrap at 2^32, and zero on reset.
REQ-027 SHALL, without BRU_STATS_EN, omit those ports and counters entirely.

Structure
REQ-028 SHALL place the queue-entry typedef and the FSM state enum in package bru_pkg.
REQ-029 SHALL implement the FIFO as sub-module bru_pred_queue, with push, pop, clear, full, empty and head ports.

Verification
REQ-030 SHALL cover this case: push pc=0x100 pred_taken=1 target=0x200, then resolve taken to 0x200 -> btb_write=1, new_pc=0x100, data=0x200, no redirect.
REQ-031 SHALL cover this case: push pc=0x104 pred_taken=0, then resolve taken to 0x300 -> redirect=1, redirect_pc=0x300 in N+1, queue empty, and a push in N+1 is dropped.
REQ-032 SHALL cover this case: push pc=0x108 pred_taken=1, then resolve is_branch=0 -> redirect_pc=0x10C, no btb_write.
REQ-033 SHALL cover this case: fill DEPTH=4, then push and resolve together -> 5th push dropped, full stays 1 until the pop is seen, and order is preserved across pointer wrap.
REQ-034 SHALL cover this case: resolve on an empty queue -> bru_underflow=1, held until reset with reset_n=0.
REQ-035 SHALL cover this case: reset asserted during FLUSH -> all outputs 0 next cycle and the FSM in RUN.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types for the branch resolution unit: prediction-queue entry layout
// and the RUN/FLUSH state encoding. Optional feature macro: BRU_STATS_EN.
package bru_pkg;

    // One in-flight prediction recorded by fetch
    typedef struct packed {
        logic [31:0] pc;
        logic        predTaken;
        logic [31:0] predTarget;
    } bru_entry_t;

    localparam int BRU_ENTRY_W = $bits(bru_entry_t);

    // RUN accepts pushes/resolves; FLUSH is the one-cycle recovery after a mispredict
    typedef enum logic {
        BRU_RUN   = 1'b0,
        BRU_FLUSH = 1'b1
    } bru_state_e;

endpackage

// File: rtl/bru_pred_queue.sv
// In-order prediction FIFO with wrap-around pointers and an occupancy count.
// A push while full is dropped even if a pop happens in the same cycle.
// Clear empties the queue; payload storage itself is never reset.
module bru_pred_queue
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [BRU_ENTRY_W-1:0] pushData,
    output logic                   full,
    output logic                   empty,
    output logic [BRU_ENTRY_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [BRU_ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wrPtr_q;
    logic [PTR_W-1:0]       rdPtr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   full_q;
    logic                   doPush;
    logic                   doPop;

    assign empty  = (count_q == '0);
    assign full   = full_q;
    assign head   = mem[rdPtr_q];
    assign doPush = push && !full_q && !clear;
    assign doPop  = pop && !empty && !clear;

    // Next occupancy: clear wins, otherwise simultaneous push and pop cancel
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (doPush && !doPop) begin
            count_d = count_q + CNT_ONE;
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointers, count and registered full flag
    always_ff @(posedge clock) begin
        if (!resetN) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            if (clear) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
            end else begin
                if (doPush) begin
                    wrPtr_q <= wrPtr_q + PTR_ONE;
                end
                if (doPop) begin
                    rdPtr_q <= rdPtr_q + PTR_ONE;
                end
            end
        end
    end

    // Payload storage, written only on an accepted push
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr_q] <= pushData;
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: compares execute-stage outcomes against the queued
// fetch predictions, updates the BTB, and redirects fetch on a mispredict.
// Optional feature macro: BRU_STATS_EN adds branch and mispredict counters.
module branch_resolution_unit
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        bru_clk,
    input  logic        bru_reset_n,
    input  logic        bru_push,
    input  logic [31:0] bru_push_pc,
    input  logic        bru_push_pred_taken,
    input  logic [31:0] bru_push_pred_target,
    output logic        bru_full,
    input  logic        bru_resolve,
    input  logic [31:0] bru_resolve_pc,
    input  logic        bru_resolve_is_branch,
    input  logic        bru_resolve_taken,
    input  logic [31:0] bru_resolve_target,
    output logic        bru_btb_write,
    output logic [31:0] bru_btb_new_pc,
    output logic [31:0] bru_btb_data,
    output logic        bru_btb_branch_taken,
    output logic        bru_redirect,
    output logic [31:0] bru_redirect_pc,
    output logic        bru_underflow
`ifdef BRU_STATS_EN
    ,
    output logic [31:0] bru_branch_count,
    output logic [31:0] bru_mispredict_count
`endif
);

    bru_state_e             state_q;
    bru_entry_t             pushEntry;
    bru_entry_t             head;
    logic [BRU_ENTRY_W-1:0] headRaw;
    logic                   queueFull;
    logic                   queueEmpty;
    logic                   resolveValid;
    logic                   doPop;
    logic                   mispredict;
    logic                   doPush;
    logic [31:0]            redirectPc_d;

    logic                   btbWrite_q;
    logic [31:0]            btbNewPc_q;
    logic [31:0]            btbData_q;
    logic                   btbTaken_q;
    logic                   redirect_q;
    logic [31:0]            redirectPc_q;
    logic                   underflow_q;

    assign pushEntry = '{pc: bru_push_pc,
                         predTaken: bru_push_pred_taken,
                         predTarget: bru_push_pred_target};
    assign head = bru_entry_t'(headRaw);

    bru_pred_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clock   (bru_clk),
        .resetN  (bru_reset_n),
        .push    (doPush),
        .pop     (doPop),
        .clear   (mispredict),
        .pushData(pushEntry),
        .full    (queueFull),
        .empty   (queueEmpty),
        .head    (headRaw)
    );

    // Resolve qualification, mispredict detection and redirect target selection
    always_comb begin
        resolveValid = bru_resolve && (state_q == BRU_RUN);
        doPop        = resolveValid && !queueEmpty;
        mispredict   = doPop &&
                       ((head.pc != bru_resolve_pc) ||
                        (bru_resolve_is_branch && (head.predTaken != bru_resolve_taken)) ||
                        (bru_resolve_taken && (head.predTarget != bru_resolve_target)) ||
                        (!bru_resolve_is_branch && head.predTaken));
        doPush       = bru_push && (state_q == BRU_RUN) && !mispredict;
        redirectPc_d = (bru_resolve_is_branch && bru_resolve_taken) ?
                       bru_resolve_target : (bru_resolve_pc + 32'd4);
    end

    // FSM plus registered BTB-update, redirect and underflow outputs
    always_ff @(posedge bru_clk) begin
        if (!bru_reset_n) begin
            state_q      <= BRU_RUN;
            btbWrite_q   <= 1'b0;
            btbNewPc_q   <= '0;
            btbData_q    <= '0;
            btbTaken_q   <= 1'b0;
            redirect_q   <= 1'b0;
            redirectPc_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            case (state_q)
                BRU_RUN:   state_q <= mispredict ? BRU_FLUSH : BRU_RUN;
                BRU_FLUSH: state_q <= BRU_RUN;
                default:   state_q <= BRU_RUN;
            endcase
            btbWrite_q <= doPop && bru_resolve_is_branch;
            if (doPop && bru_resolve_is_branch) begin
                btbNewPc_q <= bru_resolve_pc;
                btbData_q  <= bru_resolve_target;
                btbTaken_q <= bru_resolve_taken;
            end
            redirect_q <= mispredict;
            if (mispredict) begin
                redirectPc_q <= redirectPc_d;
            end
            if (resolveValid && queueEmpty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bru_full             = queueFull;
    assign bru_btb_write        = btbWrite_q;
    assign bru_btb_new_pc       = btbNewPc_q;
    assign bru_btb_data         = btbData_q;
    assign bru_btb_branch_taken = btbTaken_q;
    assign bru_redirect         = redirect_q;
    assign bru_redirect_pc      = redirectPc_q;
    assign bru_underflow        = underflow_q;

`ifdef BRU_STATS_EN
    logic [31:0] branchCount_q;
    logic [31:0] mispredictCount_q;

    // Running totals of resolved branches and mispredicts, wrapping naturally
    always_ff @(posedge bru_clk) begin
        if (!bru_reset_n) begin
            branchCount_q     <= '0;
            mispredictCount_q <= '0;
        end else begin
            if (doPop && bru_resolve_is_branch) begin
                branchCount_q <= branchCount_q + 32'd1;
            end
            if (mispredict) begin
                mispredictCount_q <= mispredictCount_q + 32'd1;
            end
        end
    end

    assign bru_branch_count     = branchCount_q;
    assign bru_mispredict_count = mispredictCount_q;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed testbench for branch_resolution_unit (default build, DEPTH=4).
module tb_branch_resolution_unit;

    logic        bru_clk;
    logic        bru_reset_n;
    logic        bru_push;
    logic [31:0] bru_push_pc;
    logic        bru_push_pred_taken;
    logic [31:0] bru_push_pred_target;
    logic        bru_full;
    logic        bru_resolve;
    logic [31:0] bru_resolve_pc;
    logic        bru_resolve_is_branch;
    logic        bru_resolve_taken;
    logic [31:0] bru_resolve_target;
    logic        bru_btb_write;
    logic [31:0] bru_btb_new_pc;
    logic [31:0] bru_btb_data;
    logic        bru_btb_branch_taken;
    logic        bru_redirect;
    logic [31:0] bru_redirect_pc;
    logic        bru_underflow;

    int total = 0;
    int bad   = 0;

    branch_resolution_unit #(
        .DEPTH(4)
    ) dut (
        .bru_clk              (bru_clk),
        .bru_reset_n          (bru_reset_n),
        .bru_push             (bru_push),
        .bru_push_pc          (bru_push_pc),
        .bru_push_pred_taken  (bru_push_pred_taken),
        .bru_push_pred_target (bru_push_pred_target),
        .bru_full             (bru_full),
        .bru_resolve          (bru_resolve),
        .bru_resolve_pc       (bru_resolve_pc),
        .bru_resolve_is_branch(bru_resolve_is_branch),
        .bru_resolve_taken    (bru_resolve_taken),
        .bru_resolve_target   (bru_resolve_target),
        .bru_btb_write        (bru_btb_write),
        .bru_btb_new_pc       (bru_btb_new_pc),
        .bru_btb_data         (bru_btb_data),
        .bru_btb_branch_taken (bru_btb_branch_taken),
        .bru_redirect         (bru_redirect),
        .bru_redirect_pc      (bru_redirect_pc),
        .bru_underflow        (bru_underflow)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        bru_clk = 1'b0;
        forever #5 bru_clk = ~bru_clk;
    end

    // Count one comparison and report it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle just after the edge
    task automatic applyStimulus(input logic push, input logic [31:0] pc,
                                 input logic predTaken, input logic [31:0] predTarget,
                                 input logic resolve, input logic [31:0] rPc,
                                 input logic isBranch, input logic taken,
                                 input logic [31:0] rTarget);
        bru_push              = push;
        bru_push_pc           = pc;
        bru_push_pred_taken   = predTaken;
        bru_push_pred_target  = predTarget;
        bru_resolve           = resolve;
        bru_resolve_pc        = rPc;
        bru_resolve_is_branch = isBranch;
        bru_resolve_taken     = taken;
        bru_resolve_target    = rTarget;
        @(posedge bru_clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pushOnly(input logic [31:0] pc, input logic predTaken,
                            input logic [31:0] predTarget);
        applyStimulus(1'b1, pc, predTaken, predTarget, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolveOnly(input logic [31:0] rPc, input logic isBranch,
                               input logic taken, input logic [31:0] rTarget);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rPc, isBranch, taken, rTarget);
    endtask

    // Directed scenario sequence
    initial begin
        bru_reset_n = 1'b0;
        idle();
        idle();
        checkOutput("rst_full", 32'(bru_full), 32'd0);
        checkOutput("rst_redirect", 32'(bru_redirect), 32'd0);
        checkOutput("rst_redirect_pc", bru_redirect_pc, 32'h0);
        checkOutput("rst_btb_write", 32'(bru_btb_write), 32'd0);
        checkOutput("rst_underflow", 32'(bru_underflow), 32'd0);
        bru_reset_n = 1'b1;

        // Correctly predicted taken branch updates the BTB without redirect
        pushOnly(32'h100, 1'b1, 32'h200);
        resolveOnly(32'h100, 1'b1, 1'b1, 32'h200);
        checkOutput("c1_btb_write", 32'(bru_btb_write), 32'd1);
        checkOutput("c1_btb_new_pc", bru_btb_new_pc, 32'h100);
        checkOutput("c1_btb_data", bru_btb_data, 32'h200);
        checkOutput("c1_btb_taken", 32'(bru_btb_branch_taken), 32'd1);
        checkOutput("c1_redirect", 32'(bru_redirect), 32'd0);
        idle();
        checkOutput("c1_btb_write_pulse", 32'(bru_btb_write), 32'd0);

        // Predicted not-taken, actually taken: redirect to the target
        pushOnly(32'h104, 1'b0, 32'h0);
        resolveOnly(32'h104, 1'b1, 1'b1, 32'h300);
        checkOutput("c2_redirect", 32'(bru_redirect), 32'd1);
        checkOutput("c2_redirect_pc", bru_redirect_pc, 32'h300);
        checkOutput("c2_btb_write", 32'(bru_btb_write), 32'd1);
        checkOutput("c2_full", 32'(bru_full), 32'd0);
        pushOnly(32'h500, 1'b0, 32'h0);
        checkOutput("c2_redirect_pulse", 32'(bru_redirect), 32'd0);
        pushOnly(32'h10, 1'b0, 32'h0);
        resolveOnly(32'h10, 1'b0, 1'b0, 32'h0);
        checkOutput("c2_flush_push_dropped", 32'(bru_redirect), 32'd0);
        checkOutput("c2_no_underflow", 32'(bru_underflow), 32'd0);

        // Non-branch that was predicted taken: redirect to pc+4, no BTB write
        pushOnly(32'h108, 1'b1, 32'h400);
        resolveOnly(32'h108, 1'b0, 1'b0, 32'h0);
        checkOutput("c3_redirect", 32'(bru_redirect), 32'd1);
        checkOutput("c3_redirect_pc", bru_redirect_pc, 32'h10C);
        checkOutput("c3_btb_write", 32'(bru_btb_write), 32'd0);
        idle();

        // Predicted taken, resolved not taken at the top of memory: pc+4 wraps
        pushOnly(32'hFFFF_FFFC, 1'b1, 32'h60);
        resolveOnly(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
        checkOutput("c3b_redirect", 32'(bru_redirect), 32'd1);
        checkOutput("c3b_redirect_pc", bru_redirect_pc, 32'h0);
        checkOutput("c3b_btb_taken", 32'(bru_btb_branch_taken), 32'd0);
        checkOutput("c3b_btb_new_pc", bru_btb_new_pc, 32'hFFFF_FFFC);
        idle();

        // Fill the queue, then push and pop together with the queue full
        for (int i = 0; i < 4; i++) begin
            pushOnly(32'h200 + 32'(4 * i), 1'b0, 32'h0);
            checkOutput($sformatf("c4_full_%0d", i), 32'(bru_full), (i == 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 32'h210, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        checkOutput("c4_full_after_pop", 32'(bru_full), 32'd0);
        checkOutput("c4_redirect_0", 32'(bru_redirect), 32'd0);
        pushOnly(32'h214, 1'b0, 32'h0);
        checkOutput("c4_full_refill", 32'(bru_full), 32'd1);
        resolveOnly(32'h204, 1'b0, 1'b0, 32'h0);
        checkOutput("c4_order_204", 32'(bru_redirect), 32'd0);
        resolveOnly(32'h208, 1'b0, 1'b0, 32'h0);
        checkOutput("c4_order_208", 32'(bru_redirect), 32'd0);
        resolveOnly(32'h20C, 1'b0, 1'b0, 32'h0);
        checkOutput("c4_order_20C", 32'(bru_redirect), 32'd0);
        resolveOnly(32'h214, 1'b0, 1'b0, 32'h0);
        checkOutput("c4_order_214_wrap", 32'(bru_redirect), 32'd0);
        checkOutput("c4_empty_no_underflow", 32'(bru_underflow), 32'd0);

        // Resolve on an empty queue sets a sticky underflow flag
        resolveOnly(32'h999, 1'b1, 1'b1, 32'h0);
        checkOutput("c5_underflow", 32'(bru_underflow), 32'd1);
        checkOutput("c5_no_btb_write", 32'(bru_btb_write), 32'd0);
        checkOutput("c5_no_redirect", 32'(bru_redirect), 32'd0);
        idle();
        idle();
        idle();
        checkOutput("c5_underflow_sticky", 32'(bru_underflow), 32'd1);
        bru_reset_n = 1'b0;
        idle();
        checkOutput("c5_underflow_reset", 32'(bru_underflow), 32'd0);
        bru_reset_n = 1'b1;

        // Reset asserted while in FLUSH with a pending redirect
        pushOnly(32'h300, 1'b0, 32'h0);
        resolveOnly(32'h300, 1'b1, 1'b1, 32'h900);
        checkOutput("c6_redirect", 32'(bru_redirect), 32'd1);
        checkOutput("c6_redirect_pc", bru_redirect_pc, 32'h900);
        bru_reset_n = 1'b0;
        idle();
        checkOutput("c6_rst_redirect", 32'(bru_redirect), 32'd0);
        checkOutput("c6_rst_redirect_pc", bru_redirect_pc, 32'h0);
        checkOutput("c6_rst_btb_write", 32'(bru_btb_write), 32'd0);
        checkOutput("c6_rst_btb_new_pc", bru_btb_new_pc, 32'h0);
        checkOutput("c6_rst_btb_data", bru_btb_data, 32'h0);
        checkOutput("c6_rst_full", 32'(bru_full), 32'd0);
        bru_reset_n = 1'b1;
        pushOnly(32'h40, 1'b0, 32'h0);
        resolveOnly(32'h40, 1'b1, 1'b0, 32'h0);
        checkOutput("c6_run_btb_write", 32'(bru_btb_write), 32'd1);
        checkOutput("c6_run_btb_new_pc", bru_btb_new_pc, 32'h40);
        checkOutput("c6_run_redirect", 32'(bru_redirect), 32'd0);
        checkOutput("c6_run_underflow", 32'(bru_underflow), 32'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
